// File: rtl/cache_pkg.sv
// Shared widths and state/grant encodings for the I/D cache memory-port arbiter.
package cache_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide physical memory port between
// the instruction cache and the data cache.
module cache_arbiter #(
    parameter int unsigned LINE_W = cache_pkg::LINE_W,
    parameter int unsigned ADDR_W = cache_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    import cache_pkg::*;

    arb_state_t state;
    arb_state_t state_next;
    grant_t     last_grant;
    logic       i_req;
    logic       d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Read data is broadcast; only the side seeing resp consumes it.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // State and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == SERVE_I) begin
                last_grant <= GRANT_I;
            end else if (state == IDLE && state_next == SERVE_D) begin
                last_grant <= GRANT_D;
            end
        end
    end

    // Next state: arbitrate only from IDLE, leave SERVE only on memory resp
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    state_next = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end else if (d_req) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I: if (pmem_resp) state_next = IDLE;
            SERVE_D: if (pmem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Port mux; outputs held quiet while reset is asserted
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        if (!rst) begin
            unique case (state)
                SERVE_I: begin
                    pmem_read    = i_pmem_read;
                    pmem_address = i_pmem_address;
                    i_pmem_resp  = pmem_resp;
                end
                SERVE_D: begin
                    // Simultaneous read+write from D is illegal; write wins.
                    pmem_write   = d_pmem_write;
                    pmem_read    = d_pmem_read & ~d_pmem_write;
                    pmem_address = d_pmem_address;
                    pmem_wdata   = d_pmem_wdata;
                    d_pmem_resp  = pmem_resp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: ownership model, line memory, directed scenarios
// and randomized two-requester traffic.
module tb_cache_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;
    localparam int NONE = 0;
    localparam int SI   = 1;
    localparam int SD   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int                side;
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic              rd;
        logic              wr;
        logic [LINE_W-1:0] wd;
    } grant_rec_t;

    typedef struct {
        int                side;
        int                cyc;
        logic [LINE_W-1:0] data;
    } resp_rec_t;

    grant_rec_t glog[$];
    resp_rec_t  rlog[$];
    int i_resp_cnt = 0;
    int d_resp_cnt = 0;

    // Memory: starts a transaction when a strobe appears, answers after mem_lat cycles
    int                mem_cnt = -1;
    int unsigned       mem_lat = 5;
    logic              mem_fixed_en = 1'b0;
    logic [LINE_W-1:0] mem_fixed = '0;

    always @(posedge clk) begin
        #1;
        if (rst || pmem_resp) begin
            pmem_resp = 1'b0;
            mem_cnt   = -1;
        end else begin
            if (mem_cnt < 0 && (pmem_read || pmem_write)) mem_cnt = int'(mem_lat) - 1;
            else if (mem_cnt > 0) mem_cnt--;
            if (mem_cnt == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = mem_fixed_en ? mem_fixed : {8{$urandom()}};
            end
        end
    end

    // Reference: who owns the port this cycle, and what the port must show
    int   m_owner = NONE;
    int   m_last  = SI;
    logic m_first = 1'b0;
    logic              e_rd, e_wr, e_ir, e_dr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wd;

    always @(negedge clk) begin
        cyc++;
        e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_addr = '0; e_wd = '0;
        if (!rst && m_owner == SI) begin
            e_rd   = i_pmem_read;
            e_addr = i_pmem_address;
            e_ir   = pmem_resp;
        end else if (!rst && m_owner == SD) begin
            e_wr   = d_pmem_write;
            e_rd   = d_pmem_read && !d_pmem_write;
            e_addr = d_pmem_address;
            e_wd   = d_pmem_wdata;
            e_dr   = pmem_resp;
        end
        chk("pmem_read",    LINE_W'(pmem_read),    LINE_W'(e_rd));
        chk("pmem_write",   LINE_W'(pmem_write),   LINE_W'(e_wr));
        chk("pmem_address", LINE_W'(pmem_address), LINE_W'(e_addr));
        chk("pmem_wdata",   pmem_wdata,            e_wd);
        chk("i_pmem_resp",  LINE_W'(i_pmem_resp),  LINE_W'(e_ir));
        chk("d_pmem_resp",  LINE_W'(d_pmem_resp),  LINE_W'(e_dr));
        chk("i_pmem_rdata", i_pmem_rdata,          pmem_rdata);
        chk("d_pmem_rdata", d_pmem_rdata,          pmem_rdata);

        if (i_pmem_resp) begin rlog.push_back('{SI, cyc, i_pmem_rdata}); i_resp_cnt++; end
        if (d_pmem_resp) begin rlog.push_back('{SD, cyc, d_pmem_rdata}); d_resp_cnt++; end
        if (m_owner != NONE && m_first) begin
            glog.push_back('{m_owner, cyc, pmem_address, pmem_read, pmem_write, pmem_wdata});
            m_first = 1'b0;
        end

        if (rst) begin
            m_owner = NONE;
            m_last  = SI;
            m_first = 1'b0;
        end else if (m_owner != NONE) begin
            if (pmem_resp) m_owner = NONE;
        end else begin
            if (i_pmem_read && (d_pmem_read || d_pmem_write)) m_owner = (m_last == SI) ? SD : SI;
            else if (i_pmem_read)                            m_owner = SI;
            else if (d_pmem_read || d_pmem_write)            m_owner = SD;
            if (m_owner != NONE) begin
                m_last  = m_owner;
                m_first = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_resp(input string name, input int side, input int target);
        int n;
        n = 0;
        while (((side == SI) ? i_resp_cnt : d_resp_cnt) < target && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL %s: no response within 100 cycles (got %0d want %0d)",
                     name, (side == SI) ? i_resp_cnt : d_resp_cnt, target);
        end
    endtask

    int n0, ri, rd, req_cyc, dresp_cyc;
    int i_act, d_act, i_seen, d_seen;

    initial begin
        repeat (3) tick();
        chk("reset_pmem_read",  LINE_W'(pmem_read),   '0);
        chk("reset_pmem_write", LINE_W'(pmem_write),  '0);
        chk("reset_i_resp",     LINE_W'(i_pmem_resp), '0);
        rst = 1'b0;
        tick();

        // I-only read with fixed A5 line
        n0 = glog.size(); ri = i_resp_cnt; rd = d_resp_cnt;
        mem_lat = 5; mem_fixed_en = 1'b1; mem_fixed = {32{8'hA5}};
        i_pmem_address = 32'h0000_0100; i_pmem_read = 1'b1; req_cyc = cyc + 1;
        wait_resp("t1_i_resp", SI, ri + 1);
        i_pmem_read = 1'b0;
        repeat (3) tick();
        chk("t1_grants", LINE_W'(glog.size() - n0), LINE_W'(1));
        if (glog.size() > n0) begin
            chk("t1_side",    LINE_W'(glog[n0].side), LINE_W'(SI));
            chk("t1_latency", LINE_W'(glog[n0].cyc),  LINE_W'(req_cyc + 1));
            chk("t1_addr",    LINE_W'(glog[n0].addr), LINE_W'(32'h100));
            chk("t1_rd",      LINE_W'(glog[n0].rd),   LINE_W'(1));
        end
        chk("t1_i_count", LINE_W'(i_resp_cnt), LINE_W'(ri + 1));
        chk("t1_d_count", LINE_W'(d_resp_cnt), LINE_W'(rd));
        chk("t1_data",    rlog[$].data, {32{8'hA5}});

        // D write-back
        n0 = glog.size(); rd = d_resp_cnt;
        d_pmem_address = 32'h0000_2040; d_pmem_wdata = {16{16'h1234}}; d_pmem_write = 1'b1;
        wait_resp("t2_d_resp", SD, rd + 1);
        d_pmem_write = 1'b0;
        tick();
        if (glog.size() > n0) begin
            chk("t2_side",  LINE_W'(glog[n0].side), LINE_W'(SD));
            chk("t2_wr",    LINE_W'(glog[n0].wr),   LINE_W'(1));
            chk("t2_rd",    LINE_W'(glog[n0].rd),   LINE_W'(0));
            chk("t2_addr",  LINE_W'(glog[n0].addr), LINE_W'(32'h2040));
            chk("t2_wdata", glog[n0].wd, {16{16'h1234}});
        end else chk("t2_grants", LINE_W'(glog.size() - n0), LINE_W'(1));
        mem_fixed_en = 1'b0;

        // Simultaneous after reset: D first, then I two cycles after D resp
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n0 = glog.size(); ri = i_resp_cnt; rd = d_resp_cnt;
        i_pmem_address = 32'h300; d_pmem_address = 32'h400;
        i_pmem_read = 1'b1; d_pmem_read = 1'b1;
        wait_resp("t3_d_resp", SD, rd + 1);
        dresp_cyc = rlog[$].cyc;
        d_pmem_read = 1'b0;
        wait_resp("t3_i_resp", SI, ri + 1);
        i_pmem_read = 1'b0;
        tick();
        chk("t3_grants", LINE_W'(glog.size() - n0), LINE_W'(2));
        if (glog.size() >= n0 + 2) begin
            chk("t3_first",  LINE_W'(glog[n0].side),     LINE_W'(SD));
            chk("t3_second", LINE_W'(glog[n0 + 1].side), LINE_W'(SI));
            chk("t3_gap",    LINE_W'(glog[n0 + 1].cyc - dresp_cyc), LINE_W'(2));
            chk("t3_i_addr", LINE_W'(glog[n0 + 1].addr), LINE_W'(32'h300));
        end

        // Fairness: both sides hold requests; grants must alternate D,I,D,I
        n0 = glog.size(); ri = i_resp_cnt; rd = d_resp_cnt;
        i_pmem_read = 1'b1; d_pmem_read = 1'b1;
        wait_resp("t4_d1", SD, rd + 1);
        wait_resp("t4_i1", SI, ri + 1);
        wait_resp("t4_d2", SD, rd + 2);
        wait_resp("t4_i2", SI, ri + 2);
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        tick();
        chk("t4_grants", LINE_W'(glog.size() - n0), LINE_W'(4));
        if (glog.size() >= n0 + 4) begin
            chk("t4_g0", LINE_W'(glog[n0].side),     LINE_W'(SD));
            chk("t4_g1", LINE_W'(glog[n0 + 1].side), LINE_W'(SI));
            chk("t4_g2", LINE_W'(glog[n0 + 2].side), LINE_W'(SD));
            chk("t4_g3", LINE_W'(glog[n0 + 3].side), LINE_W'(SI));
        end

        // Dirty miss with I pending: D-write, I-read, D-read
        n0 = glog.size(); ri = i_resp_cnt; rd = d_resp_cnt;
        d_pmem_address = 32'h0000_7fe0; d_pmem_wdata = {8{32'hdead_beef}}; d_pmem_write = 1'b1;
        tick();
        i_pmem_address = 32'h0000_0500; i_pmem_read = 1'b1;
        wait_resp("t5_wb", SD, rd + 1);
        d_pmem_write = 1'b0; d_pmem_address = 32'h0000_1fe0; d_pmem_read = 1'b1;
        wait_resp("t5_i", SI, ri + 1);
        i_pmem_read = 1'b0;
        wait_resp("t5_alloc", SD, rd + 2);
        d_pmem_read = 1'b0;
        tick();
        chk("t5_grants", LINE_W'(glog.size() - n0), LINE_W'(3));
        if (glog.size() >= n0 + 3) begin
            chk("t5_g0_side", LINE_W'(glog[n0].side),     LINE_W'(SD));
            chk("t5_g0_wr",   LINE_W'(glog[n0].wr),       LINE_W'(1));
            chk("t5_g0_addr", LINE_W'(glog[n0].addr),     LINE_W'(32'h7fe0));
            chk("t5_g1_side", LINE_W'(glog[n0 + 1].side), LINE_W'(SI));
            chk("t5_g1_addr", LINE_W'(glog[n0 + 1].addr), LINE_W'(32'h500));
            chk("t5_g2_side", LINE_W'(glog[n0 + 2].side), LINE_W'(SD));
            chk("t5_g2_rd",   LINE_W'(glog[n0 + 2].rd),   LINE_W'(1));
            chk("t5_g2_addr", LINE_W'(glog[n0 + 2].addr), LINE_W'(32'h1fe0));
        end

        // Reset during cycle 3 of a 6-cycle D read
        n0 = glog.size(); rd = d_resp_cnt; mem_lat = 6;
        d_pmem_address = 32'h600; d_pmem_read = 1'b1;
        for (int k = 0; k < 20 && glog.size() == n0; k++) tick();
        chk("t6_granted", LINE_W'(glog.size() - n0), LINE_W'(1));
        tick();
        rst = 1'b1; d_pmem_read = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6_read",  LINE_W'(pmem_read),    '0);
        chk("t6_write", LINE_W'(pmem_write),   '0);
        chk("t6_addr",  LINE_W'(pmem_address), '0);
        repeat (10) tick();
        chk("t6_no_resp",  LINE_W'(d_resp_cnt),  LINE_W'(rd));
        chk("t6_no_grant", LINE_W'(glog.size() - n0), LINE_W'(1));

        // Randomized traffic against the ownership model
        i_act = 0; d_act = 0; i_seen = i_resp_cnt; d_seen = d_resp_cnt;
        for (int k = 0; k < 3000; k++) begin
            tick();
            mem_lat = $urandom_range(1, 6);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
                i_act = 0; d_act = 0;
            end else begin
                if (i_act != 0) begin
                    if (i_resp_cnt != i_seen || $urandom_range(0, 99) == 0) begin
                        i_pmem_read = 1'b0; i_act = 0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    i_pmem_address = $urandom() & 32'hffff_ffe0;
                    i_pmem_read = 1'b1; i_act = 1; i_seen = i_resp_cnt;
                end
                if (d_act != 0) begin
                    if (d_resp_cnt != d_seen || $urandom_range(0, 99) == 0) begin
                        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_act = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    d_pmem_address = $urandom() & 32'hffff_ffe0;
                    d_pmem_wdata   = {8{$urandom()}};
                    case ($urandom_range(0, 7))
                        0:       begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
                        1, 2, 3: begin d_pmem_read = 1'b1; d_pmem_write = 1'b0; end
                        default: begin d_pmem_read = 1'b0; d_pmem_write = 1'b1; end
                    endcase
                    d_act = 1; d_seen = d_resp_cnt;
                end
            end
        end
        rst = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction cache and the data cache of the pipelined core. Each cache controller issues whole-line (256-bit) reads and write-backs exactly as it would to a private memory. The arbiter grants one requester at a time with round-robin fairness and forwards that requester's request and response. It sits between the two cache controllers and the memory model / L2 interface.

## Interface
- Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, byte address width
- Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_pmem_read  in  1  I-cache line read request
- i_pmem_address  in  ADDR_W  I-cache line address (bits [4:0] zero)
- i_pmem_rdata  out  LINE_W  read line to I-cache
- i_pmem_resp  out  1  I-cache transaction done
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache write-back request
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  D-cache write-back line
- d_pmem_rdata  out  LINE_W  read line to D-cache
- d_pmem_resp  out  1  D-cache transaction done
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transaction done

## Operation
- States:
  - IDLE: no memory request is driven.
  - SERVE_I: I-cache is granted.
  - SERVE_D: D-cache is granted.
- Register last_grant (I or D) records the most recent grant.
- Request signals: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
- Transitions out of IDLE:
  - Only i_req asserted: go to SERVE_I.
  - Only d_req asserted: go to SERVE_D.
  - Both asserted: grant the side not equal to last_grant. last_grant updates on entry to the SERVE state.
  - Neither asserted: stay in IDLE.
- SERVE_x behaviour:
  - pmem_read, pmem_write, pmem_address and pmem_wdata are combinationally driven from requester x.
  - I side: pmem_write = 0 and pmem_wdata = 0.
- Response handling:
  - pmem_resp is forwarded combinationally to x_pmem_resp only.
  - The other side's resp stays 0.
  - On pmem_resp, go to IDLE.
- Read data: pmem_rdata is broadcast to both i_pmem_rdata and d_pmem_rdata at all times. It is only meaningful to the side whose resp is high.
- D-cache read and write asserted together is a protocol violation. pmem_write takes precedence and pmem_read is forced to 0.
- If the granted requester drops its request before pmem_resp, the arbiter still waits in SERVE_x for pmem_resp. Strobes follow the requester (they go to 0).
- Dirty-miss sequence: write-back then allocate is two separate transactions, and the arbiter re-arbitrates between them. A pending I-cache request may be serviced in between. This is correct because the D line is already written back.

## Timing
- Reset state: IDLE; last_grant = I, so the first tie goes to D.
- Every output is 0 in IDLE and during/after reset, except the rdata broadcasts, which follow pmem_rdata.
- Grant latency: a request seen in IDLE on cycle N drives pmem_* from cycle N+1.
- Response latency: x_pmem_resp equals pmem_resp in the same cycle (zero added latency).
- After resp, there is exactly one IDLE cycle before the next grant. This bubble lets the cache FSMs deassert their requests, so no stale request is re-granted.
- A back-to-back request from the same side waits at least 1 IDLE cycle. It loses a tie against a waiting other side.
- rst asserted mid-transaction: return to IDLE next cycle and drop all strobes. The memory model is reset in the same cycle.

## Structure
- Shared package cache_pkg:
  - LINE_W and ADDR_W constants.
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}.
  - grant_t enum {GRANT_I, GRANT_D}.
- No sub-module: one always_ff for state/last_grant, one always_comb for next state, one always_comb for output muxing.

## Test plan
- I-only: i_pmem_read=1, address 0x0000_0100, memory resp after 5 cycles with rdata=256'hA5... -> pmem_read=1, pmem_address=0x100 from cycle 1. i_pmem_resp pulses once with A5 data. d_pmem_resp stays 0.
- D write-back: d_pmem_write=1, address 0x0000_2040, wdata=256'h1234... -> pmem_write=1, pmem_wdata matches. d_pmem_resp on pmem_resp. pmem_read stays 0.
- Simultaneous after reset: both request on the same cycle -> D granted first, then IDLE bubble, then I. The second grant starts exactly 2 cycles after the first resp.
- Fairness: D requests continuously while I requests -> grants alternate D, I, D, I. No side is granted twice in a row while the other waits.
- Dirty miss with I pending: D write-back, then D read, with I waiting -> order is D-write, I-read, D-read. Addresses are correct on each.
- Reset mid-SERVE_D (cycle 3 of 6): all strobes go to 0 in the next cycle, state is IDLE, and no resp is forwarded for the aborted transaction.
